// File: rtl/bram_stream_sink_pkg.sv
// Shared widths, depth and state encodings for bram_stream_sink and its bench.
// The three-bit state values are kept as plain constants so legacy code can reuse them.
package bram_stream_sink_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 7;
    localparam int MEM_DEPTH  = 128;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/bram_stream_sink.sv
// Captures a run of stream beats into an external single-port BRAM, reads them back
// and flags a mismatch between the write-side and read-back checksums.
module bram_stream_sink
    import bram_stream_sink_pkg::*;
#(
    parameter int DWIDTH   = DATA_WIDTH,
    parameter int AWIDTH   = ADDR_WIDTH,
    parameter int MEM_SIZE = MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_run,
    input  logic [AWIDTH-1:0]        i_num_cnt,
    output logic                     o_idle,
    output logic                     o_recv,
    output logic                     o_check,
    output logic                     o_done,
    input  logic                     i_valid,
    input  logic [DWIDTH-1:0]        i_data,
    output logic [AWIDTH-1:0]        addr0,
    output logic                     ce0,
    output logic                     we0,
    output logic [DWIDTH-1:0]        d0,
    input  logic [DWIDTH-1:0]        q0,
    output logic [DWIDTH+AWIDTH-1:0] o_sum,
    output logic                     o_err,
    output logic                     o_drop
);

    localparam int SWIDTH = DWIDTH + AWIDTH;
    localparam logic [AWIDTH-1:0] MAX_N = AWIDTH'(MEM_SIZE - 1);

    logic [2:0]        r_state;
    logic [AWIDTH-1:0] r_n;
    logic [AWIDTH-1:0] r_wr_cnt;
    logic [AWIDTH-1:0] r_rd_cnt;
    logic [SWIDTH-1:0] r_sum;
    logic [SWIDTH-1:0] r_rd_sum;
    logic              r_rd_vld;
    logic              r_err;
    logic              r_drop;

    logic [2:0]        w_next;
    logic              w_start;
    logic              w_wr_last;
    logic              w_rd_last;
    logic [SWIDTH-1:0] w_rd_sum_nxt;

    assign w_start      = (r_state == S_IDLE) && i_run;
    assign w_wr_last    = (r_wr_cnt == r_n - AWIDTH'(1));
    assign w_rd_last    = (r_rd_cnt == r_n - AWIDTH'(1));
    assign w_rd_sum_nxt = r_rd_sum + SWIDTH'(q0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        w_next = r_state;
        ce0    = 1'b0;
        we0    = 1'b0;
        addr0  = '0;
        d0     = '0;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = (i_num_cnt == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                if (i_valid) begin
                    ce0   = 1'b1;
                    we0   = 1'b1;
                    addr0 = r_wr_cnt;
                    d0    = i_data;
                    if (w_wr_last) w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                ce0   = 1'b1;
                addr0 = r_rd_cnt;
                if (w_rd_last) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // BRAM contents live outside this block and are deliberately left alone on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_sum    <= '0;
            r_rd_sum <= '0;
            r_rd_vld <= 1'b0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state  <= w_next;
            r_rd_vld <= ce0 & ~we0;

            if (r_state == S_RECV && i_valid) begin
                r_sum    <= r_sum + SWIDTH'(i_data);
                r_wr_cnt <= r_wr_cnt + AWIDTH'(1);
            end
            if (r_state == S_CHECK) r_rd_cnt <= r_rd_cnt + AWIDTH'(1);

            // q0 trails the read address by one cycle; DRAIN picks up the final word.
            if (r_rd_vld) r_rd_sum <= w_rd_sum_nxt;
            if (r_state == S_DRAIN) r_err <= (w_rd_sum_nxt != r_sum);

            if (i_valid && r_state != S_RECV) r_drop <= 1'b1;

            if (w_start) begin
                r_n      <= (i_num_cnt > MAX_N) ? MAX_N : i_num_cnt;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
                r_sum    <= '0;
                r_rd_sum <= '0;
                r_err    <= 1'b0;
                r_drop   <= 1'b0;
            end
        end
    end

    assign o_idle  = (r_state == S_IDLE);
    assign o_recv  = (r_state == S_RECV);
    assign o_check = (r_state == S_CHECK) || (r_state == S_DRAIN);
    assign o_done  = (r_state == S_DONE);
    assign o_sum   = r_sum;
    assign o_err   = r_err;
    assign o_drop  = r_drop;

endmodule

// File: tb/tb_bram_stream_sink.sv
// Directed bench for bram_stream_sink with a behavioural single-port BRAM alongside it;
// BRAM writes and per-run results are checked against scoreboard queues.
module tb_bram_stream_sink;
    import bram_stream_sink_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int SW = DATA_WIDTH + ADDR_WIDTH;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [SW-1:0] sum;
        logic          err;
        logic          drop;
        int            cyc;
    } res_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_run = 1'b0;
    logic [AW-1:0] i_num_cnt = '0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_idle, o_recv, o_check, o_done;
    logic [AW-1:0] addr0;
    logic          ce0, we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0 = '0;
    logic [SW-1:0] o_sum;
    logic          o_err, o_drop;

    logic [DW-1:0] mem [MEM_DEPTH];
    bit            flip5 = 1'b0;

    int total = 0;
    int bad   = 0;
    int last_recv, last_ce;
    logic [DW-1:0] beats [$];
    wr_t  wr_q  [$];
    res_t res_q [$];

    always #5 clk = ~clk;

    bram_stream_sink dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_recv(o_recv), .o_check(o_check), .o_done(o_done),
        .i_valid(i_valid), .i_data(i_data),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
        .o_sum(o_sum), .o_err(o_err), .o_drop(o_drop)
    );

    // Memory model; optionally corrupts bit 0 of word 5 on read.
    always @(posedge clk) begin
        if (ce0) begin
            if (we0) mem[addr0] <= d0;
            else     q0 <= mem[addr0] ^ {{(DW-1){1'b0}}, (flip5 && addr0 == AW'(5))};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".idle"},  32'(o_idle),  32'd1);
        check({tag, ".recv"},  32'(o_recv),  32'd0);
        check({tag, ".check"}, 32'(o_check), 32'd0);
        check({tag, ".done"},  32'(o_done),  32'd0);
        check({tag, ".sum"},   32'(o_sum),   32'd0);
        check({tag, ".err"},   32'(o_err),   32'd0);
        check({tag, ".drop"},  32'(o_drop),  32'd0);
        check({tag, ".bram"},  {addr0, ce0, we0, d0}, 32'd0);
    endtask

    // Starts a run of n beats from `beats`, spacing them by `gap` idle cycles; a nonzero
    // abort_cyc pulses reset in that cycle instead of letting the run finish.
    task automatic run(input string tag, input int n, input int nbeats, input int gap,
                       input bit exp_err, input int abort_cyc);
        res_t exp;
        res_t got;
        wr_t  w;
        int   b = 0;
        bit   done = 1'b0;
        exp.sum  = '0;
        for (int i = 0; i < n; i++) exp.sum += SW'(beats[i]);
        exp.err  = exp_err;
        exp.drop = (nbeats > n);
        exp.cyc  = (n == 0) ? 1 : (n - 1) * (gap + 1) + 1 + n + 2;
        res_q.push_back(exp);
        last_recv = 0;
        last_ce   = 0;

        @(negedge clk);
        i_run     = 1'b1;
        i_num_cnt = AW'(n);
        for (int cyc = 1; cyc <= 1000 && !done; cyc++) begin
            @(negedge clk);
            i_run = 1'b0;
            if (cyc == abort_cyc) begin
                reset_n = 1'b0;
                i_valid = 1'b0;
                #1;
                check_reset_outputs({tag, ".abort"});
                wr_q.delete();
                res_q.delete();
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (o_recv) last_recv++;
            if (o_done) begin
                done = 1'b1;
                if (res_q.size() == 0) check({tag, ".res_q_empty"}, 32'd1, 32'd0);
                else begin
                    got = res_q.pop_front();
                    check({tag, ".done_cycle"}, 32'(cyc),    32'(got.cyc));
                    check({tag, ".sum"},        32'(o_sum),  32'(got.sum));
                    check({tag, ".err"},        32'(o_err),  32'(got.err));
                    check({tag, ".drop"},       32'(o_drop), 32'(got.drop));
                end
            end
            i_valid = 1'b0;
            if (!done && b < nbeats && (cyc - 1) % (gap + 1) == 0) begin
                i_valid = 1'b1;
                i_data  = beats[b];
                if (b < n) begin
                    w.addr = AW'(b);
                    w.data = beats[b];
                    wr_q.push_back(w);
                end
                b++;
            end
            #1;
            if (ce0) last_ce++;
            if (ce0 && we0) begin
                if (wr_q.size() == 0) check({tag, ".unexpected_write"}, {addr0, d0}, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    check({tag, ".wr_addr"}, 32'(addr0), 32'(w.addr));
                    check({tag, ".wr_data"}, 32'(d0),    32'(w.data));
                end
            end
        end
        i_valid = 1'b0;
        if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
        check({tag, ".writes_left"}, 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        beats.delete();
        for (int k = 0; k < 100; k++) beats.push_back(DW'(k));
        run("n100", 100, 100, 0, 1'b0, 0);
        check("n100.sum_const", 32'(o_sum), 32'd4950);
        check("n100.recv_cycles", 32'(last_recv), 32'd100);
        check("n100.mem0",  32'(mem[0]),  32'd0);
        check("n100.mem57", 32'(mem[57]), 32'd57);
        check("n100.mem99", 32'(mem[99]), 32'd99);

        beats.delete();
        for (int k = 0; k < 10; k++) beats.push_back(16'hFFFF);
        run("gap", 10, 10, 1, 1'b0, 0);
        check("gap.sum_const", 32'(o_sum), 32'h9FFF6);
        check("gap.recv_cycles", 32'(last_recv), 32'd19);

        beats.delete();
        run("n0", 0, 0, 0, 1'b0, 0);
        check("n0.ce_cycles", 32'(last_ce), 32'd0);

        beats.delete();
        for (int k = 1; k <= 6; k++) beats.push_back(DW'(10 * k));
        run("drop", 4, 6, 0, 1'b0, 0);
        check("drop.sum_const", 32'(o_sum), 32'd100);

        beats.delete();
        for (int k = 0; k < 8; k++) beats.push_back(DW'(3 * k + 1));
        flip5 = 1'b1;
        run("flip", 8, 8, 0, 1'b1, 0);
        flip5 = 1'b0;
        check("flip.sum_const", 32'(o_sum), 32'd92);

        beats.delete();
        for (int k = 0; k < 100; k++) beats.push_back(DW'(1000 + k));
        run("abort", 100, 100, 0, 1'b0, 40);
        check("abort.mem38", 32'(mem[38]), 32'd1038);

        beats.delete();
        for (int k = 7; k <= 9; k++) beats.push_back(DW'(k));
        run("fresh", 3, 3, 0, 1'b0, 0);
        check("fresh.sum_const", 32'(o_sum), 32'd24);

        @(negedge clk);
        check("final.idle", 32'(o_idle), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_stream_sink.md
Name: bram_stream_sink

Overview:
- Receiving end of the BRAM read-out stream (o_valid/o_mem_data) produced by simple_bram_ctrl.
- Captures a run of i_num_cnt beats into a second true_dpbram instance through its single port.
- Reads the run back, compares the write-side checksum with the read-back checksum, and reports done, sum and error.
- Sits downstream of simple_bram_ctrl in memory-copy and self-check designs.

Parameters:
- DWIDTH, 16, data word width.
- AWIDTH, 7, address and count width.
- MEM_SIZE, 128, BRAM depth in words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_num_cnt  in  AWIDTH  number of beats to capture; latched on start.
- o_idle  out  1  high in IDLE.
- o_recv  out  1  high in RECV.
- o_check  out  1  high in CHECK and DRAIN.
- o_done  out  1  one-cycle pulse in DONE.
- i_valid  in  1  input beat strobe; no backpressure.
- i_data  in  DWIDTH  input beat data.
- addr0  out  AWIDTH  BRAM address.
- ce0  out  1  BRAM chip enable.
- we0  out  1  BRAM write enable.
- d0  out  DWIDTH  BRAM write data.
- q0  in  DWIDTH  BRAM read data; valid one cycle after a read.
- o_sum  out  DWIDTH+AWIDTH  write-side checksum, unsigned sum of captured beats.
- o_err  out  1  read-back sum differs from o_sum; valid from DONE until the next start.
- o_drop  out  1  sticky flag: i_valid seen outside RECV since the last start.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - o_idle=1; all other outputs 0; counters, sums and latched count cleared.
  - BRAM contents are untouched.
- States: IDLE, RECV, CHECK, DRAIN, DONE, encoded in 3 bits.
- IDLE:
  - i_run=1 at a clock edge latches i_num_cnt into N, clears both sums, o_err and o_drop.
  - Next state is RECV, or DONE when N=0.
  - i_run is ignored in every other state.
- RECV:
  - Each cycle with i_valid=1 drives, combinationally in the same cycle: ce0=1, we0=1, addr0=wr_cnt, d0=i_data.
  - On that edge: o_sum += i_data (zero-extended); wr_cnt increments.
  - Cycles with i_valid=0 have no effect; gaps of any length are allowed.
  - After beat N is accepted, next state is CHECK.
- CHECK:
  - Each cycle drives ce0=1, we0=0, addr0=rd_cnt; rd_cnt increments.
  - Next cycle, q0 is added to rd_sum; the valid flag for this add is a registered ce0&~we0.
  - After address N-1 is issued, next state is DRAIN.
- DRAIN:
  - ce0=0.
  - Adds the last q0 into rd_sum.
  - o_err <= (rd_sum + q0) != o_sum.
  - Next state is DONE.
- DONE:
  - o_done=1 for exactly one cycle; next state is IDLE.
  - o_sum, o_err and o_drop hold until the next accepted start.
- Outside RECV and CHECK: ce0=we0=0, addr0=0, d0=0.
- i_valid outside RECV: beat discarded, o_drop set; no BRAM access.
- Beats arriving after beat N while in CHECK or DRAIN count as drops.
- Timing, with cycle 1 = first cycle after start and back-to-back input:
  - RECV in cycles 1..N.
  - CHECK in cycles N+1..2N.
  - DRAIN in cycle 2N+1.
  - o_done in cycle 2N+2.
- N=0: o_done in cycle 1, o_sum=0, o_err=0.
- Counters are AWIDTH bits. N ≤ MEM_SIZE-1 by construction, so addresses never wrap.
- o_sum width DWIDTH+AWIDTH cannot overflow for N ≤ 2^AWIDTH-1.
- Reset asserted mid-RECV or mid-CHECK aborts the run; the partial write stays in BRAM.

Decomposition:
- Shared defines header holds ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH and the state encodings (S_IDLE .. S_DONE). The bench uses the same header.
- Single flat module, no sub-module; true_dpbram is instanced alongside it in the bench, not inside.

Test Plan:
- N=100, i_data=k for k=0..99, back-to-back -> o_sum=4950, o_err=0, o_done in cycle 202, BRAM[k]=k.
- N=10, data 16'hFFFF with 1-cycle gaps between beats -> o_sum=655350 (0x9FFF6), o_err=0, o_recv high for 19 cycles.
- N=0 with i_run pulse -> o_done in cycle 1, o_sum=0, no ce0 activity.
- N=4, 6 valid beats driven -> beats 5-6 discarded, o_drop=1, o_sum = sum of first 4 beats, o_err=0.
- Bench memory model flips bit0 of word 5 on read, N=8 -> o_err=1 at DONE, o_sum unchanged.
- reset_n low for 1 cycle during beat 40 of N=100 -> all outputs at reset values; a fresh run with N=3 then completes with o_err=0.
